// File: rtl/lab71_soc_pio_in_irq.sv
// ---------------------------------------------------------------------------
// lab71_soc_pio_in_irq
// Avalon-MM parallel input port with per-bit edge capture and a level IRQ.
// External inputs are synchronised, edges are detected against the previous
// synchronised sample, latched into EDGECAP and gated by IRQMASK.
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data, only [WIDTH-1:0] used
//   in_port     asynchronous external inputs
//   readdata    registered read data, 1-cycle latency, zero-extended
//   irq         level interrupt, active-high, registered
// ---------------------------------------------------------------------------
module lab71_soc_pio_in_irq #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;

  logic [WIDTH-1:0] sync_q_s;
  logic [WIDTH-1:0] edge_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic [WIDTH-1:0] irqmask_nxt_s;
  logic [WIDTH-1:0] edgecap_nxt_s;
  logic [31:0]      rd_sel_s;
  logic             unused_wdata_s;

  assign sync_q_s = sync_r[SYNC_STAGES-1];
  assign wr_en_s  = chipselect & ~write_n;

  // Upper writedata bits are intentionally ignored.
  assign unused_wdata_s = ^writedata;

  // Synchroniser chain and one-clock-delayed copy of its last stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_q_s;
    end
  end

  // Per-bit edge detect selected by EDGE_TYPE.
  always_comb begin
    edge_s = '0;
    case (EDGE_TYPE)
      0:       edge_s = sync_q_s & ~prev_r;
      1:       edge_s = ~sync_q_s & prev_r;
      2:       edge_s = sync_q_s ^ prev_r;
      default: edge_s = sync_q_s & ~prev_r;
    endcase
  end

  // Next-state of IRQMASK and EDGECAP; a set wins over a same-cycle clear.
  always_comb begin
    cap_clr_s     = '0;
    irqmask_nxt_s = irqmask_r;
    if (wr_en_s && (address == 2'd3)) begin
      cap_clr_s = writedata[WIDTH-1:0];
    end else begin
      cap_clr_s = '0;
    end
    if (wr_en_s && (address == 2'd2)) begin
      irqmask_nxt_s = writedata[WIDTH-1:0];
    end else begin
      irqmask_nxt_s = irqmask_r;
    end
    edgecap_nxt_s = (edgecap_r & ~cap_clr_s) | edge_s;
  end

  // Read mux; EDGECAP reads its pre-clear value because the current register is used.
  always_comb begin
    rd_sel_s = 32'd0;
    case (address)
      2'd0:    rd_sel_s[WIDTH-1:0] = sync_q_s;
      2'd1:    rd_sel_s = 32'd0;
      2'd2:    rd_sel_s[WIDTH-1:0] = irqmask_r;
      2'd3:    rd_sel_s[WIDTH-1:0] = edgecap_r;
      default: rd_sel_s = 32'd0;
    endcase
  end

  // Control registers, read data and irq. irq is computed from next-state
  // values so it rises right after the capturing edge yet stays a flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r <= '0;
      edgecap_r <= '0;
      readdata  <= 32'd0;
      irq       <= 1'b0;
    end else begin
      irqmask_r <= irqmask_nxt_s;
      edgecap_r <= edgecap_nxt_s;
      readdata  <= rd_sel_s;
      irq       <= |(edgecap_nxt_s & irqmask_nxt_s);
    end
  end

endmodule

// File: tb/tb_lab71_soc_pio_in_irq.sv
// ---------------------------------------------------------------------------
// tb_lab71_soc_pio_in_irq
// Self-checking bench: a rising-edge instance (dut_rise) and an any-edge
// instance (dut_any) share the bus. Vectors carry hand-derived expectations;
// each applied vector pushes its expectation onto a scoreboard queue which is
// popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_lab71_soc_pio_in_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  vin;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [7:0]  wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [31:0] rd;
    logic        irq;
    string       tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  lab71_soc_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  lab71_soc_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] vin, input logic cs, input logic wn,
                     input logic [1:0] addr, input logic [7:0] wd,
                     input logic [31:0] rd, input logic irq_e);
    vec_t v;
    v.vin = vin; v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.rd = rd; v.irq = irq_e;
    tbl.push_back(v);
  endtask

  // Drive one vector, push its expectation, clock, then pop and compare.
  task automatic step(input logic sel, input logic [7:0] vin, input logic cs,
                      input logic wn, input logic [1:0] addr, input logic [7:0] wd,
                      input logic [31:0] erd, input logic eirq, input string tag);
    exp_t e;
    exp_t got;
    if (sel) in_b = vin; else in_a = vin;
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = {24'd0, wd};
    e.sel = sel; e.rd = erd; e.irq = eirq; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, " readdata"}, got.sel ? rd_b : rd_a, got.rd);
    check({got.tag, " irq"}, got.sel ? {31'd0, irq_b} : {31'd0, irq_a}, {31'd0, got.irq});
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0; in_a = 8'h00; in_b = 8'h00;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_a = 8'h00; in_b = 8'h00;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;

    // Rising-edge instance: vin, cs, wn, addr, wd, expected readdata, expected irq.
    add(8'hA5,1,1,2'd0,8'h00,32'h00,1'b0);  // DATA path latency
    add(8'hA5,1,1,2'd0,8'h00,32'h00,1'b0);
    add(8'hA5,1,1,2'd0,8'h00,32'hA5,1'b0);
    add(8'hA5,1,1,2'd3,8'h00,32'hA5,1'b0);
    add(8'hA5,1,0,2'd3,8'hFF,32'hA5,1'b0);  // pre-clear read value
    add(8'hA5,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h00,1,0,2'd2,8'h04,32'h00,1'b0);  // IRQMASK = 04
    add(8'h00,1,1,2'd2,8'h00,32'h04,1'b0);
    add(8'h00,1,1,2'd0,8'h00,32'h00,1'b0);  // falling bits give no capture
    add(8'h04,1,1,2'd3,8'h00,32'h00,1'b0);  // bit2 rises before edge k
    add(8'h04,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h04,1,1,2'd3,8'h00,32'h00,1'b1);  // captured at k+2, irq
    add(8'h04,1,0,2'd3,8'h04,32'h04,1'b0);  // W1C, irq drops
    add(8'h04,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h05,1,0,2'd2,8'h00,32'h04,1'b0);  // mask off, bit0 rises
    add(8'h05,1,1,2'd1,8'h00,32'h00,1'b0);
    add(8'h05,1,1,2'd3,8'h00,32'h00,1'b0);  // captured but masked
    add(8'h05,1,0,2'd2,8'h01,32'h00,1'b1);  // unmask -> irq next cycle
    add(8'h05,1,1,2'd3,8'h00,32'h01,1'b1);
    add(8'h0D,1,0,2'd2,8'h09,32'h01,1'b1);  // bit3 rises
    add(8'h0D,1,1,2'd3,8'h00,32'h01,1'b1);
    add(8'h0D,1,0,2'd3,8'h08,32'h01,1'b1);  // set and clear collide on bit3
    add(8'h0D,1,1,2'd3,8'h00,32'h09,1'b1);
    add(8'h0D,1,0,2'd3,8'h01,32'h09,1'b1);
    add(8'h0D,1,0,2'd1,8'hFF,32'h00,1'b1);  // reserved write ignored
    add(8'h0D,1,1,2'd3,8'h00,32'h08,1'b1);
    add(8'h0D,1,1,2'd2,8'h00,32'h09,1'b1);
    add(8'h0D,1,0,2'd3,8'hFF,32'h08,1'b0);
    add(8'h0D,0,0,2'd2,8'hFF,32'h09,1'b0);  // write without chipselect
    add(8'h0D,1,1,2'd2,8'h00,32'h09,1'b0);
    add(8'h00,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h00,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h00,1,1,2'd3,8'h00,32'h00,1'b0);
    add(8'h00,1,1,2'd0,8'h00,32'h00,1'b0);

    #12;
    check("reset readdata rise", rd_a, 32'd0);
    check("reset irq rise", {31'd0, irq_a}, 32'd0);
    check("reset readdata any", rd_b, 32'd0);
    check("reset irq any", {31'd0, irq_b}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].vin, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd,
           tbl[i].rd, tbl[i].irq, $sformatf("row%0d", i));
    end

    // Any-edge instance: bit1 0->1->0, each edge captured and cleared.
    reset_pulse();
    step(1'b1, 8'h00, 1'b1, 1'b0, 2'd2, 8'h02, 32'h00, 1'b0, "any mask");
    step(1'b1, 8'h02, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "any rise k");
    step(1'b1, 8'h02, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "any rise k1");
    step(1'b1, 8'h02, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b1, "any rise cap");
    step(1'b1, 8'h02, 1'b1, 1'b0, 2'd3, 8'h02, 32'h02, 1'b0, "any rise clr");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "any fall k");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "any fall k1");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b1, "any fall cap");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h02, 1'b1, "any fall read");
    step(1'b1, 8'h00, 1'b1, 1'b0, 2'd1, 8'hFF, 32'h00, 1'b1, "any rsvd wr");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h02, 1'b1, "any cap kept");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd2, 8'h00, 32'h02, 1'b1, "any mask kept");
    step(1'b1, 8'h00, 1'b1, 1'b0, 2'd3, 8'h02, 32'h02, 1'b0, "any fall clr");
    step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "any cleared");

    // Reset mid-operation with everything captured and unmasked.
    reset_pulse();
    step(1'b0, 8'hFF, 1'b1, 1'b0, 2'd2, 8'hFF, 32'h00, 1'b0, "mid mask");
    step(1'b0, 8'hFF, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "mid k1");
    step(1'b0, 8'hFF, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b1, "mid cap");
    step(1'b0, 8'hFF, 1'b1, 1'b1, 2'd3, 8'h00, 32'hFF, 1'b1, "mid full");
    in_a = 8'h00;
    #2;
    reset_n = 1'b0;
    #1;
    check("async readdata", rd_a, 32'd0);
    check("async irq", {31'd0, irq_a}, 32'd0);
    reset_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "post cap0");
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h00, 32'h00, 1'b0, "post cap1");
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h00, 32'h00, 1'b0, "post cap2");
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h00, 32'h00, 1'b0, "post mask");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
